sdram_responder: RTL

Synthesizable SDR SDRAM device responder: the chip side of the 16-bit SDR SDRAM command bus that our controller drives. It decodes CS/RAS/CAS/WE commands, tracks the mode register and the open row per bank, and serves read/write bursts from an internal word array. It is used in simulation and on-FPGA loopback builds in place of the external SDRAM. It flags protocol violations for the bench and for debug LEDs.

---
 rtl/sdram_pkg.sv | 66 ++++++
 rtl/sdram_responder_bank.sv | 30 +++
 rtl/sdram_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command opcodes, mode-register fields,
// burst/latency encodings, error codes and small decode helpers.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BTERM = 4'b0110,
    CMD_NOP   = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    INIT_WAIT_PRE  = 2'd0,
    INIT_COUNT_REF = 2'd1,
    INIT_DONE      = 2'd2
  } init_state_e;

  localparam int MRS_BT_BIT = 3;
  localparam int MRS_WB_BIT = 9;
  localparam int A10_BIT    = 10;

  localparam logic [2:0] BL_1    = 3'b000;
  localparam logic [2:0] BL_2    = 3'b001;
  localparam logic [2:0] BL_4    = 3'b010;
  localparam logic [2:0] BL_8    = 3'b011;
  localparam logic [2:0] BL_PAGE = 3'b111;
  localparam logic [2:0] CL_2    = 3'd2;
  localparam logic [2:0] CL_3    = 3'd3;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_IDLE_BANK  = 3'd1;
  localparam logic [2:0] ERR_ACT_ACTIVE = 3'd2;
  localparam logic [2:0] ERR_REF_ACTIVE = 3'd3;
  localparam logic [2:0] ERR_NOT_INIT   = 3'd4;
  localparam logic [2:0] ERR_BAD_MRS    = 3'd5;

  // Reserved op-mode bits [8:7] and high bits [12:10] must be zero as well.
  function automatic logic mrs_valid(input logic [12:0] a);
    logic bl_ok;
    case (a[2:0])
      BL_1, BL_2, BL_4, BL_8, BL_PAGE: bl_ok = 1'b1;
      default:                         bl_ok = 1'b0;
    endcase
    return bl_ok && !a[MRS_BT_BIT] && ((a[6:4] == CL_2) || (a[6:4] == CL_3))
           && (a[8:7] == 2'b00) && (a[12:10] == 3'b000);
  endfunction

  function automatic logic [8:0] bl_mask(input logic [2:0] bl);
    case (bl)
      BL_1:    return 9'h000;
      BL_2:    return 9'h001;
      BL_4:    return 9'h003;
      BL_8:    return 9'h007;
      default: return 9'h1FF;
    endcase
  endfunction

  function automatic logic [8:0] col_next(input logic [8:0] col, input logic [8:0] mask);
    return (col & ~mask) | ((col + 9'd1) & mask);
  endfunction

endpackage

// File: rtl/sdram_responder_bank.sv
// One SDRAM bank: active flag plus the low row bits latched by ACT.
module sdram_responder_bank
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 2
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                act,
  input  logic                pre,
  input  logic                pre_all,
  input  logic [ROW_BITS-1:0] row_in,
  output logic                active,
  output logic [ROW_BITS-1:0] row
);

  // Open/close the bank; row only changes on ACT.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      active <= 1'b0;
      row    <= {ROW_BITS{1'b0}};
    end else if (act) begin
      active <= 1'b1;
      row    <= row_in;
    end else if (pre || pre_all) begin
      active <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device model: command decode, init/mode tracking, burst engine,
// word array and CAS-latency read pipeline on the shared 16-bit dq bus.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS     = 2,
  parameter int INIT_MIN_REF = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  input  logic [1:0]  dqm,
  inout  wire  [15:0] dq,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int IDX_BITS = 11 + ROW_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  cmd_e                cmd_s;
  init_state_e         init_state_r, init_next_s;
  logic [3:0]          ref_cnt_r, ref_cnt_next_s;
  logic                mrs_ok_s, pre_all_s, act_ok_s, rw_ok_s;
  logic                wr_start_s, rd_start_s, stop_s;
  logic [3:0]          act_s, pre_s, bank_active_s;
  logic [ROW_BITS-1:0] bank_row_s [4];
  logic                err_hit_s;
  logic [2:0]          err_code_s;
  logic [2:0]          bl_r;
  logic                cl3_r, single_wr_r;
  logic [8:0]          burst_mask_s, burst_left_r, burst_col_r, slot_col_s;
  logic [1:0]          burst_bank_r, slot_bank_s;
  logic                burst_write_r, slot_rd_s, slot_wr_s;
  logic [IDX_BITS-1:0] slot_idx_s;
  logic [15:0]         mem [DEPTH];
  logic [1:0]          pipe_valid_r, out_oe_r, dqm_prev_r;
  logic [15:0]         pipe_data_r [2];
  logic [15:0]         out_data_r;

  // With cke low or chip deselected the edge carries no command.
  assign cmd_s        = (cke && !cs_n) ? cmd_e'({1'b0, ras_n, cas_n, we_n}) : CMD_NOP;
  assign mrs_ok_s     = mrs_valid(addr);
  assign pre_all_s    = (cmd_s == CMD_PRE) && addr[A10_BIT];
  assign act_ok_s     = init_done && !bank_active_s[ba];
  assign rw_ok_s      = init_done && bank_active_s[ba];
  assign act_s        = ((cmd_s == CMD_ACT) && act_ok_s) ? (4'b0001 << ba) : 4'b0000;
  assign pre_s        = ((cmd_s == CMD_PRE) && !addr[A10_BIT]) ? (4'b0001 << ba) : 4'b0000;
  assign wr_start_s   = (cmd_s == CMD_WRITE) && rw_ok_s;
  assign rd_start_s   = (cmd_s == CMD_READ) && rw_ok_s;
  assign stop_s       = (cmd_s == CMD_BTERM) ||
                        ((cmd_s == CMD_PRE) && (addr[A10_BIT] || (ba == burst_bank_r)));
  assign burst_mask_s = bl_mask(bl_r);

  for (genvar i = 0; i < 4; i++) begin : g_bank
    sdram_responder_bank #(.ROW_BITS(ROW_BITS)) u_bank (
      .clk     (clk),
      .res_n   (res_n),
      .act     (act_s[i]),
      .pre     (pre_s[i]),
      .pre_all (pre_all_s),
      .row_in  (addr[ROW_BITS-1:0]),
      .active  (bank_active_s[i]),
      .row     (bank_row_s[i])
    );
  end

  // Init sequencer: PRE-all, enough REFs, then a valid MRS.
  always_comb begin
    init_next_s    = init_state_r;
    ref_cnt_next_s = ref_cnt_r;
    case (init_state_r)
      INIT_WAIT_PRE: begin
        if (pre_all_s) begin
          init_next_s    = INIT_COUNT_REF;
          ref_cnt_next_s = 4'd0;
        end else begin
          init_next_s = INIT_WAIT_PRE;
        end
      end
      INIT_COUNT_REF: begin
        if (pre_all_s) begin
          ref_cnt_next_s = 4'd0;
        end else if ((cmd_s == CMD_REF) && (ref_cnt_r != 4'hF)) begin
          ref_cnt_next_s = ref_cnt_r + 4'd1;
        end else if ((cmd_s == CMD_MRS) && mrs_ok_s && (ref_cnt_r >= 4'(INIT_MIN_REF))) begin
          init_next_s = INIT_DONE;
        end else begin
          init_next_s = INIT_COUNT_REF;
        end
      end
      INIT_DONE: init_next_s = INIT_DONE;
      default:   init_next_s = INIT_WAIT_PRE;
    endcase
  end

  // Init state register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      init_state_r <= INIT_WAIT_PRE;
      ref_cnt_r    <= 4'd0;
      init_done    <= 1'b0;
    end else begin
      init_state_r <= init_next_s;
      ref_cnt_r    <= ref_cnt_next_s;
      init_done    <= (init_next_s == INIT_DONE);
    end
  end

  // Protocol violation classification for the current edge.
  always_comb begin
    err_hit_s  = 1'b0;
    err_code_s = ERR_NONE;
    case (cmd_s)
      CMD_ACT: begin
        if (!init_done) begin
          err_hit_s = 1'b1; err_code_s = ERR_NOT_INIT;
        end else if (bank_active_s[ba]) begin
          err_hit_s = 1'b1; err_code_s = ERR_ACT_ACTIVE;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      CMD_READ, CMD_WRITE: begin
        if (!init_done) begin
          err_hit_s = 1'b1; err_code_s = ERR_NOT_INIT;
        end else if (!bank_active_s[ba]) begin
          err_hit_s = 1'b1; err_code_s = ERR_IDLE_BANK;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      CMD_REF: begin
        err_hit_s  = |bank_active_s;
        err_code_s = ERR_REF_ACTIVE;
      end
      CMD_MRS: begin
        err_hit_s  = !mrs_ok_s;
        err_code_s = ERR_BAD_MRS;
      end
      default: err_hit_s = 1'b0;
    endcase
  end

  // First violation wins and is held until reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (err_hit_s && !err) begin
      err      <= 1'b1;
      err_code <= err_code_s;
    end
  end

  // Mode register; rejected MRS leaves it untouched.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bl_r        <= BL_1;
      cl3_r       <= 1'b0;
      single_wr_r <= 1'b0;
    end else if ((cmd_s == CMD_MRS) && mrs_ok_s) begin
      bl_r        <= addr[2:0];
      cl3_r       <= (addr[6:4] == CL_3);
      single_wr_r <= addr[MRS_WB_BIT];
    end
  end

  // Which array word this edge touches, if any.
  always_comb begin
    slot_rd_s   = 1'b0;
    slot_wr_s   = 1'b0;
    slot_bank_s = burst_bank_r;
    slot_col_s  = burst_col_r;
    if (wr_start_s || rd_start_s) begin
      slot_wr_s   = wr_start_s;
      slot_rd_s   = rd_start_s;
      slot_bank_s = ba;
      slot_col_s  = addr[8:0];
    end else if (cke && !stop_s && (burst_left_r != 9'd0)) begin
      slot_wr_s = burst_write_r;
      slot_rd_s = !burst_write_r;
    end else begin
      slot_wr_s = 1'b0;
      slot_rd_s = 1'b0;
    end
  end

  assign slot_idx_s = {slot_bank_s, bank_row_s[slot_bank_s], slot_col_s};

  // Burst engine: burst_left_r counts words still due after the current one.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      burst_left_r  <= 9'd0;
      burst_write_r <= 1'b0;
      burst_bank_r  <= 2'd0;
      burst_col_r   <= 9'd0;
    end else if (cke) begin
      if (wr_start_s || rd_start_s) begin
        burst_write_r <= wr_start_s;
        burst_bank_r  <= ba;
        burst_col_r   <= col_next(slot_col_s, burst_mask_s);
        burst_left_r  <= (wr_start_s && single_wr_r) ? 9'd0 : burst_mask_s;
      end else if (stop_s) begin
        burst_left_r <= 9'd0;
      end else if (burst_left_r != 9'd0) begin
        burst_col_r  <= col_next(burst_col_r, burst_mask_s);
        burst_left_r <= burst_left_r - 9'd1;
      end
    end
  end

  // Array has no reset so its contents survive res_n.
  always_ff @(posedge clk) begin
    if (slot_wr_s) begin
      if (!dqm[0]) mem[slot_idx_s][7:0]  <= dq[7:0];
      if (!dqm[1]) mem[slot_idx_s][15:8] <= dq[15:8];
    end
  end

  // Read pipeline: fetch stage, optional CL3 stage, then dqm-masked output register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pipe_valid_r   <= 2'b00;
      pipe_data_r[0] <= 16'h0000;
      pipe_data_r[1] <= 16'h0000;
      out_oe_r       <= 2'b00;
      out_data_r     <= 16'h0000;
      dqm_prev_r     <= 2'b00;
    end else if (cke) begin
      dqm_prev_r <= dqm;
      if (wr_start_s) begin
        pipe_valid_r <= 2'b00;
        out_oe_r     <= 2'b00;
      end else begin
        pipe_valid_r[0] <= slot_rd_s;
        pipe_data_r[0]  <= mem[slot_idx_s];
        pipe_valid_r[1] <= pipe_valid_r[0];
        pipe_data_r[1]  <= pipe_data_r[0];
        out_oe_r        <= {2{cl3_r ? pipe_valid_r[1] : pipe_valid_r[0]}} & ~dqm_prev_r;
        out_data_r      <= cl3_r ? pipe_data_r[1] : pipe_data_r[0];
      end
    end
  end

  assign dq[7:0]  = out_oe_r[0] ? out_data_r[7:0]  : 8'bzzzz_zzzz;
  assign dq[15:8] = out_oe_r[1] ? out_data_r[15:8] : 8'bzzzz_zzzz;

endmodule
